ifetch_unit: RTL and testbench
==============================

Name: ifetch_unit

Overview:
RV32 instruction fetch stage sitting directly upstream of the decode stage. Holds the PC and issues in-order word fetches to instruction memory over a valid/ready request channel with a fixed-order response channel. Buffers returned instructions in a small FIFO and presents {inst, inst_addr} to decode with a valid/ready handshake. Accepts a redirect from later stages (branch/jump) that retargets the PC and squashes all buffered and in-flight fetches.

Parameters:
RESET_PC, 32'h8000_0000, PC value loaded on reset.
FIFO_DEPTH, 2, instruction buffer entries; also the maximum number of in-flight plus buffered fetches; power of two, >= 2.

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request this cycle
imem_req_addr  out  32  fetch word address (= PC)
imem_rsp_valid  in  1  response valid; responses return in request order, at least one cycle after acceptance
imem_rsp_data  in  32  fetched instruction word
redirect_valid  in  1  redirect PC this cycle
redirect_pc  in  32  new PC
inst_valid_o  out  1  instruction valid to decode
inst_ready_i  in  1  decode accepts instruction
inst_o  out  32  instruction word to decode
inst_addr_o  out  32  address of inst_o
misalign_o  out  1  present only with IFU_MISALIGN_CHECK_EN

Behaviour:
- Reset (rst=1 at edge): pc=RESET_PC, FIFO empty, inflight=0, drop=0. Outputs: imem_req_valid=0 during the reset cycle; imem_req_addr=RESET_PC; inst_valid_o=0; inst_o=0; inst_addr_o=0; misalign_o=0. Reset mid-operation discards everything. Responses arriving after reset, for requests accepted before reset, are ignored while drop=0 is undefined usage; memory must also be reset.
- Occupancy = fifo_count + inflight + drop. imem_req_valid = !rst && !redirect_valid && occupancy < FIFO_DEPTH. imem_req_addr = pc, combinational from the register.
- Request fire (valid && ready): pc <= pc + 4 (wraps modulo 2^32); push pc into an in-flight address queue (depth FIFO_DEPTH); inflight++.
- Response (imem_rsp_valid): if drop>0, drop-- and discard data. Else pop the in-flight address queue, inflight--, and push {addr, data} into the FIFO. A response with drop=0 and inflight=0 is a protocol error and is ignored.
- Decode handshake: inst_valid_o = fifo_count!=0 && !redirect_valid; inst_o/inst_addr_o = FIFO head (registered storage, no bypass). Pop on inst_valid_o && inst_ready_i. Push and pop in the same cycle keep the count unchanged, including when full.
- Fetch-to-decode latency: request accepted at cycle N, response at cycle M>N, instruction visible at M+1.
- Redirect (redirect_valid=1): pc <= redirect_pc; FIFO flushed (count=0); drop <= drop + inflight; inflight queue cleared; no request issued and no decode handshake that cycle. A response in the same cycle is counted as discarded: new drop = drop + inflight - 1 if the response was against old state. Redirect has priority over every other event.
- No FSM beyond counters; widths: counts are clog2(FIFO_DEPTH)+1 bits and never exceed FIFO_DEPTH in total.

Optional Feature:
IFU_MISALIGN_CHECK_EN: defined -> redirect_pc[1:0]!=0 latches misalign_o=1, sets pc to redirect_pc, and suppresses requests (imem_req_valid=0) until the next redirect with aligned pc or reset; inst_valid_o drains the remaining FIFO (empty after the redirect). Undefined -> port absent, redirect_pc[1:0] ignored (pc <= {redirect_pc[31:2],2'b00}).

Test Plan:
- Reset, then imem_req_ready=1 with 1-cycle response latency and inst_ready_i=1 -> requests at 8000_0000, 8000_0004, 8000_0008; decode sees the same addresses in order, each with its data.
- inst_ready_i=0 for 10 cycles -> at most 2 requests are issued, FIFO holds 2 entries, imem_req_valid=0; on release, entries drain in order and fetch resumes at 8000_0008.
- imem_req_ready toggling 1,0,1 -> imem_req_addr held constant while not ready; no duplicate or skipped PC.
- Two requests in flight, then redirect_pc=8000_0100 -> both responses discarded (drop 2→0), the next request address is 8000_0100, and the first decode output is 8000_0100.
- Redirect in the same cycle as a response and a decode-ready -> inst_valid_o=0 that cycle, the response is discarded, and the FIFO is empty next cycle.
- (IFU_MISALIGN_CHECK_EN) redirect_pc=8000_0102 -> misalign_o=1 and no requests; then redirect_pc=8000_0200 -> misalign_o=0 and fetch resumes at 8000_0200.

Source files
------------

// File: rtl/ifetch_unit.sv
// RV32 instruction fetch: PC, in-order imem requests, response buffer FIFO and decode handshake.
// Optional build macro IFU_MISALIGN_CHECK_EN adds misalign_o and halts fetch on a misaligned redirect.
module ifetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h8000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid_o,
   input  logic        inst_ready_i,
   output logic [31:0] inst_o,
   output logic [31:0] inst_addr_o
`ifdef IFU_MISALIGN_CHECK_EN
   ,
   output logic        misalign_o
`endif
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [AW-1:0] PTR_ZERO  = {AW{1'b0}};
   localparam logic [AW-1:0] PTR_ONE   = AW'(1'b1);
   localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE   = CW'(1'b1);
   localparam logic [CW:0]   DEPTH_LIM = (CW+1)'(FIFO_DEPTH);

   logic [31:0]   pc_q, pc_d;
   logic [31:0]   fifo_inst_q [FIFO_DEPTH];
   logic [31:0]   fifo_addr_q [FIFO_DEPTH];
   logic [31:0]   aq_addr_q   [FIFO_DEPTH];
   logic [AW-1:0] fifo_rd_q, fifo_rd_d, fifo_wr_q, fifo_wr_d;
   logic [AW-1:0] aq_rd_q, aq_rd_d, aq_wr_q, aq_wr_d;
   logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
   logic [CW-1:0] inflight_q, inflight_d;
   logic [CW-1:0] drop_q, drop_d;
   logic [CW:0]   occupancy_s;
   logic [31:0]   redir_target_s;
   logic          fetch_block_s;
   logic          req_fire_s, rsp_drop_s, rsp_take_s, rsp_counted_s, pop_s;

`ifdef IFU_MISALIGN_CHECK_EN
   logic misalign_q, misalign_d;

   assign redir_target_s = redirect_pc;
   assign fetch_block_s  = misalign_q;
   assign misalign_o     = misalign_q;

   // Misalign flag follows the alignment of the most recent redirect target
   always_comb begin
      if (redirect_valid) begin
         misalign_d = (redirect_pc[1:0] != 2'b00);
      end else begin
         misalign_d = misalign_q;
      end
   end

   // Misalign flag register
   always_ff @(posedge clk) begin
      if (rst) begin
         misalign_q <= 1'b0;
      end else begin
         misalign_q <= misalign_d;
      end
   end
`else
   assign redir_target_s = redirect_pc & 32'hFFFF_FFFC;
   assign fetch_block_s  = 1'b0;
`endif

   // Drop slots count toward occupancy so squashed responses can never overrun the FIFO
   assign occupancy_s    = {1'b0, fifo_cnt_q} + {1'b0, inflight_q} + {1'b0, drop_q};
   assign imem_req_valid = !rst && !redirect_valid && !fetch_block_s && (occupancy_s < DEPTH_LIM);
   assign imem_req_addr  = pc_q;
   assign req_fire_s     = imem_req_valid && imem_req_ready;
   assign rsp_drop_s     = imem_rsp_valid && (drop_q != CNT_ZERO);
   assign rsp_take_s     = imem_rsp_valid && (drop_q == CNT_ZERO) && (inflight_q != CNT_ZERO);
   assign rsp_counted_s  = rsp_drop_s || rsp_take_s;
   assign inst_valid_o   = (fifo_cnt_q != CNT_ZERO) && !redirect_valid;
   assign pop_s          = inst_valid_o && inst_ready_i;
   assign inst_o         = fifo_inst_q[fifo_rd_q];
   assign inst_addr_o    = fifo_addr_q[fifo_rd_q];

   // Next-state for PC, queue pointers and counters; redirect overrides every other event
   always_comb begin
      pc_d       = pc_q;
      fifo_rd_d  = fifo_rd_q;
      fifo_wr_d  = fifo_wr_q;
      aq_rd_d    = aq_rd_q;
      aq_wr_d    = aq_wr_q;
      fifo_cnt_d = fifo_cnt_q;
      inflight_d = inflight_q;
      drop_d     = drop_q;
      if (redirect_valid) begin
         pc_d       = redir_target_s;
         fifo_rd_d  = PTR_ZERO;
         fifo_wr_d  = PTR_ZERO;
         aq_rd_d    = PTR_ZERO;
         aq_wr_d    = PTR_ZERO;
         fifo_cnt_d = CNT_ZERO;
         inflight_d = CNT_ZERO;
         drop_d     = drop_q + inflight_q - (rsp_counted_s ? CNT_ONE : CNT_ZERO);
      end else begin
         if (req_fire_s) begin
            pc_d    = pc_q + 32'd4;
            aq_wr_d = aq_wr_q + PTR_ONE;
         end else begin
            pc_d    = pc_q;
            aq_wr_d = aq_wr_q;
         end
         if (rsp_take_s) begin
            aq_rd_d   = aq_rd_q + PTR_ONE;
            fifo_wr_d = fifo_wr_q + PTR_ONE;
         end else begin
            aq_rd_d   = aq_rd_q;
            fifo_wr_d = fifo_wr_q;
         end
         if (pop_s) begin
            fifo_rd_d = fifo_rd_q + PTR_ONE;
         end else begin
            fifo_rd_d = fifo_rd_q;
         end
         inflight_d = inflight_q + (req_fire_s ? CNT_ONE : CNT_ZERO) - (rsp_take_s ? CNT_ONE : CNT_ZERO);
         fifo_cnt_d = fifo_cnt_q + (rsp_take_s ? CNT_ONE : CNT_ZERO) - (pop_s ? CNT_ONE : CNT_ZERO);
         drop_d     = drop_q - (rsp_drop_s ? CNT_ONE : CNT_ZERO);
      end
   end

   // PC, pointer and counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q       <= RESET_PC;
         fifo_rd_q  <= PTR_ZERO;
         fifo_wr_q  <= PTR_ZERO;
         aq_rd_q    <= PTR_ZERO;
         aq_wr_q    <= PTR_ZERO;
         fifo_cnt_q <= CNT_ZERO;
         inflight_q <= CNT_ZERO;
         drop_q     <= CNT_ZERO;
      end else begin
         pc_q       <= pc_d;
         fifo_rd_q  <= fifo_rd_d;
         fifo_wr_q  <= fifo_wr_d;
         aq_rd_q    <= aq_rd_d;
         aq_wr_q    <= aq_wr_d;
         fifo_cnt_q <= fifo_cnt_d;
         inflight_q <= inflight_d;
         drop_q     <= drop_d;
      end
   end

   // Storage: in-flight address queue and {addr, inst} buffer; cleared on reset so outputs read zero
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_inst_q[i] <= 32'h0000_0000;
            fifo_addr_q[i] <= 32'h0000_0000;
            aq_addr_q[i]   <= 32'h0000_0000;
         end
      end else begin
         if (req_fire_s) begin
            aq_addr_q[aq_wr_q] <= pc_q;
         end
         if (rsp_take_s && !redirect_valid) begin
            fifo_inst_q[fifo_wr_q] <= imem_rsp_data;
            fifo_addr_q[fifo_wr_q] <= aq_addr_q[aq_rd_q];
         end
      end
   end

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: memory model, scoreboard of expected decode outputs, redirect table.
module tb_ifetch_unit;

   localparam logic [31:0] RESET_PC = 32'h8000_0000;
   localparam int          DEPTH    = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req_valid, imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_valid_o, inst_ready_i;
   logic [31:0] inst_o, inst_addr_o;
`ifdef IFU_MISALIGN_CHECK_EN
   logic        misalign_o;
`endif

   always #5 clk = ~clk;

   ifetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i),
      .inst_o(inst_o), .inst_addr_o(inst_addr_o)
`ifdef IFU_MISALIGN_CHECK_EN
      , .misalign_o(misalign_o)
`endif
   );

   typedef struct {
      logic [31:0] rpc;
      logic [7:0]  rdy_pat;
      int          lat;
      logic [31:0] exp_first;
   } vec_t;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } mreq_t;

   vec_t        vecs[5];
   mreq_t       mem_q[$];
   logic [31:0] exp_q[$];
   logic [31:0] fire_log[$];
   logic [31:0] pop_log[$];
   logic [31:0] exp_pc;
   int          m_fifo, m_inflight, m_drop;
   bit          m_mis;
   int          cyc, lat, dut_fires;
   int          nvec, nerr;

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return {a[15:0] ^ 16'hC3A5, a[31:16] + 16'h0101};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One clock: entered at negedge with imem_req_ready/inst_ready_i already set by caller
   task automatic run_cycle(input logic redir, input logic [31:0] rpc);
      logic exp_rv, exp_iv, m_fire, m_pop, rsp_cnt;
      logic [31:0] a;
      redirect_valid = redir;
      redirect_pc    = rpc;
      if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mem_data(mem_q[0].addr);
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = 32'h0000_0000;
      end
      #3;
      exp_rv = !redir && !m_mis && (m_fifo + m_inflight + m_drop < DEPTH);
      exp_iv = !redir && (m_fifo != 0);
      chk("req_valid", imem_req_valid, exp_rv);
      chk("inst_valid", inst_valid_o, exp_iv);
      if (exp_rv) chk("req_addr", imem_req_addr, exp_pc);
      m_fire = exp_rv && imem_req_ready;
      m_pop  = exp_iv && inst_ready_i;
      if (imem_req_valid && imem_req_ready) begin
         dut_fires++;
         fire_log.push_back(imem_req_addr);
         mem_q.push_back('{addr: imem_req_addr, due: cyc + lat});
      end
      if (inst_valid_o && inst_ready_i) pop_log.push_back(inst_addr_o);
      if (m_pop) begin
         a = exp_q.pop_front();
         chk("inst_addr", inst_addr_o, a);
         chk("inst_data", inst_o, mem_data(a));
      end
      rsp_cnt = imem_rsp_valid && (m_drop > 0 || m_inflight > 0);
      if (imem_rsp_valid) void'(mem_q.pop_front());
      if (redir) begin
         m_drop     = m_drop + m_inflight - (rsp_cnt ? 1 : 0);
         m_inflight = 0;
         m_fifo     = 0;
         exp_q.delete();
`ifdef IFU_MISALIGN_CHECK_EN
         exp_pc = rpc;
         m_mis  = (rpc[1:0] != 2'b00);
`else
         exp_pc = {rpc[31:2], 2'b00};
`endif
      end else begin
         if (imem_rsp_valid && m_drop > 0) m_drop--;
         else if (imem_rsp_valid && m_inflight > 0) begin m_inflight--; m_fifo++; end
         if (m_fire) begin exp_q.push_back(exp_pc); exp_pc += 32'd4; m_inflight++; end
         if (m_pop) m_fifo--;
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic run_n(input int n);
      for (int i = 0; i < n; i++) run_cycle(1'b0, 32'h0000_0000);
   endtask

   task automatic do_reset();
      rst = 1'b1; redirect_valid = 1'b0; imem_rsp_valid = 1'b0;
      imem_req_ready = 1'b1; inst_ready_i = 1'b0;
      mem_q.delete();
      #3;
      chk("rst_req_valid", imem_req_valid, 1'b0);
      @(posedge clk);
      cyc++;
      @(negedge clk);
      rst = 1'b0;
      exp_pc = RESET_PC; m_fifo = 0; m_inflight = 0; m_drop = 0; m_mis = 1'b0;
      exp_q.delete();
      #1;
      chk("rst_req_addr", imem_req_addr, RESET_PC);
      chk("rst_inst_valid", inst_valid_o, 1'b0);
      chk("rst_inst", inst_o, 32'h0000_0000);
      chk("rst_inst_addr", inst_addr_o, 32'h0000_0000);
`ifdef IFU_MISALIGN_CHECK_EN
      chk("rst_misalign", misalign_o, 1'b0);
`endif
   endtask

   initial begin
      bit found;
      nvec = 0; nerr = 0; cyc = 0; lat = 1; dut_fires = 0;
      redirect_pc = 32'h0000_0000; imem_rsp_data = 32'h0000_0000;
      vecs[0] = '{rpc: 32'h8000_0400, rdy_pat: 8'hFF,        lat: 1, exp_first: 32'h8000_0400};
      vecs[1] = '{rpc: 32'hFFFF_FFF8, rdy_pat: 8'hFF,        lat: 2, exp_first: 32'hFFFF_FFF8};
      vecs[2] = '{rpc: 32'h0000_0000, rdy_pat: 8'b1010_0110, lat: 3, exp_first: 32'h0000_0000};
      vecs[3] = '{rpc: 32'h1234_5670, rdy_pat: 8'b0111_0001, lat: 1, exp_first: 32'h1234_5670};
      vecs[4] = '{rpc: 32'h8000_0100, rdy_pat: 8'hFF,        lat: 4, exp_first: 32'h8000_0100};
      @(negedge clk);
      do_reset();

      // Streaming fetch with one-cycle memory latency
      lat = 1; imem_req_ready = 1'b1; inst_ready_i = 1'b1;
      fire_log.delete(); pop_log.delete();
      run_n(12);
      if (fire_log.size() >= 3 && pop_log.size() >= 3) begin
         chk("seq_req0", fire_log[0], 32'h8000_0000);
         chk("seq_req1", fire_log[1], 32'h8000_0004);
         chk("seq_req2", fire_log[2], 32'h8000_0008);
         chk("seq_dec0", pop_log[0], 32'h8000_0000);
         chk("seq_dec2", pop_log[2], 32'h8000_0008);
      end else chk("seq_count", 32'(fire_log.size()), 32'd3);

      // Decode stall: at most DEPTH requests, then fetch resumes in order
      do_reset();
      lat = 1; imem_req_ready = 1'b1; inst_ready_i = 1'b0; dut_fires = 0;
      run_n(10);
      chk("bp_fires", 32'(dut_fires), 32'd2);
      chk("bp_req_valid", imem_req_valid, 1'b0);
      chk("bp_inst_valid", inst_valid_o, 1'b1);
      fire_log.delete();
      inst_ready_i = 1'b1;
      run_n(8);
      if (fire_log.size() > 0) chk("bp_resume", fire_log[0], 32'h8000_0008);
      else chk("bp_resume_none", 32'(fire_log.size()), 32'd1);

      // Request-ready toggling: address held while stalled (checked every cycle)
      for (int i = 0; i < 16; i++) begin
         imem_req_ready = (i % 3) != 1;
         run_cycle(1'b0, 32'h0000_0000);
      end
      imem_req_ready = 1'b1;

      // Two in flight, then redirect: both responses must be dropped
      do_reset();
      lat = 4; imem_req_ready = 1'b1; inst_ready_i = 1'b1; dut_fires = 0;
      run_n(2);
      chk("rd_inflight", 32'(dut_fires), 32'd2);
      run_cycle(1'b1, 32'h8000_0100);
      fire_log.delete(); pop_log.delete();
      for (int i = 0; i < 30 && pop_log.size() == 0; i++) run_cycle(1'b0, 32'h0000_0000);
      if (pop_log.size() > 0 && fire_log.size() > 0) begin
         chk("rd_first_req", fire_log[0], 32'h8000_0100);
         chk("rd_first_dec", pop_log[0], 32'h8000_0100);
      end else chk("rd_timeout", 32'(pop_log.size()), 32'd1);

      // Redirect coinciding with a response and a ready decode
      lat = 1;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (mem_q.size() > 0 && mem_q[0].due <= cyc && m_fifo != 0) found = 1'b1;
         else run_cycle(1'b0, 32'h0000_0000);
      end
      if (found) begin
         run_cycle(1'b1, 32'h8000_0300);
         chk("co_fifo_empty", inst_valid_o, 1'b0);
         run_n(10);
      end else chk("co_timeout", 32'(found), 32'd1);

      // Redirect table
      for (int v = 0; v < 5; v++) begin
         lat = vecs[v].lat;
         run_cycle(1'b1, vecs[v].rpc);
         pop_log.delete();
         for (int j = 0; j < 60 && pop_log.size() < 3; j++) begin
            imem_req_ready = vecs[v].rdy_pat[j % 8];
            run_cycle(1'b0, 32'h0000_0000);
         end
         if (pop_log.size() > 0) chk("tbl_first", pop_log[0], vecs[v].exp_first);
         else chk("tbl_timeout", 32'(v), 32'hFFFF_FFFF);
      end
      imem_req_ready = 1'b1;
      lat = 1;

`ifdef IFU_MISALIGN_CHECK_EN
      run_cycle(1'b1, 32'h8000_0102);
      chk("mis_set", misalign_o, 1'b1);
      dut_fires = 0;
      run_n(10);
      chk("mis_no_req", 32'(dut_fires), 32'd0);
      chk("mis_hold", misalign_o, 1'b1);
      fire_log.delete();
      run_cycle(1'b1, 32'h8000_0200);
      chk("mis_clr", misalign_o, 1'b0);
      for (int i = 0; i < 20 && fire_log.size() == 0; i++) run_cycle(1'b0, 32'h0000_0000);
      if (fire_log.size() > 0) chk("mis_resume", fire_log[0], 32'h8000_0200);
      else chk("mis_timeout", 32'(fire_log.size()), 32'd1);
`else
      run_cycle(1'b1, 32'h8000_0203);
      pop_log.delete();
      for (int i = 0; i < 20 && pop_log.size() == 0; i++) run_cycle(1'b0, 32'h0000_0000);
      if (pop_log.size() > 0) chk("lowbits_ignored", pop_log[0], 32'h8000_0200);
      else chk("lowbits_timeout", 32'(pop_log.size()), 32'd1);
`endif
      run_n(6);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
